add_sweep_checker: RTL and testbench
====================================

// Module: add_sweep_checker
// PURPOSE
//  Self-checking initiator for the registered 4-bit adder (add_module family).
//  On start, drives every operand pair (a,b) into the adder and samples the
//  returned sum after a fixed latency. Compares each sample against a+b and
//  reports error count, first failing pair and pass/done. Built-in test engine.
// PARAMETERS
//  WIDTH    4  operand width; sum input is WIDTH+1 bits
//  LATENCY  1  adder clocks from operand change to valid c (0 = combinational)
// PORTS
//  clk          in   1          system clock, rising edge
//  rst_n        in   1          async active-low reset
//  start        in   1          1-cycle request to begin a sweep; ignored while busy
//  a            out  WIDTH      operand A to adder (registered)
//  b            out  WIDTH      operand B to adder (registered)
//  c            in   WIDTH+1    sum returned by adder
//  busy         out  1          high from the cycle after start until DONE entry
//  done         out  1          high in DONE; held until next accepted start
//  pass         out  1          done && err_cnt==0
//  err_cnt      out  2*WIDTH+1  mismatch count, saturating at all-ones
//  fail_a       out  WIDTH      a of first mismatch; valid when err_cnt!=0
//  fail_b       out  WIDTH      b of first mismatch; valid when err_cnt!=0
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all outputs 0 (a, b, busy, done, pass,
//   err_cnt, fail_a, fail_b). Reset mid-sweep aborts immediately; no partial
//   result is kept. After release, the sweep runs only on a new start.
//  FSM: IDLE -> DRIVE -> (WAIT) -> CHECK -> DRIVE | DONE; DONE -> DRIVE on start.
//  IDLE/DONE + start: clear err_cnt/fail_a/fail_b/done; a=0, b=0; go DRIVE.
//  DRIVE: a,b stable for this pair; wait counter loaded with LATENCY.
//   LATENCY=0: compare in the DRIVE cycle itself; WAIT/CHECK are bypassed.
//  WAIT: hold a,b; decrement counter; when it reaches 0, go to CHECK.
//  CHECK: sample c at the clock edge exactly LATENCY cycles after a,b first
//   appeared; a,b are held throughout the pair.
//  Compare: expected = {1'b0,a} + {1'b0,b} in WIDTH+1 bits; no truncation.
//   Mismatch: err_cnt+1 (saturate). If err_cnt was 0, latch fail_a/fail_b.
//  Pair order: b is the inner index, a is the outer index, both from 0.
//   Step: b+1; on b wrap to 0, a+1. The pair after (max,max) goes to DONE.
//   Total 2^(2*WIDTH) pairs. Each pair takes LATENCY+1 cycles.
//  DONE: busy=0, done=1, pass per err_cnt; a,b hold the last pair.
//  start while busy: ignored; no effect on pair index or counters.
//  start and reset together: reset wins.
//  Total sweep latency from the start cycle to done=1:
//   2^(2*WIDTH)*(LATENCY+1)+1 cycles.
// TESTING
//  1 Golden registered adder, LATENCY=1, start at cycle 10 -> done=1 at
//    cycle 10+513; err_cnt=0; pass=1.
//  2 Adder with c[4] stuck-at-0 -> err_cnt=120; fail_a=1; fail_b=15; pass=0.
//  3 Pulse start at sweep cycle 50 and again at cycle 200 -> no restart;
//    run length 513 cycles; result matches scenario 1.
//  4 Drive rst_n=0 for 1 cycle at sweep cycle 100 -> a=b=0, busy=0,
//    err_cnt=0 in the same cycle. Then start -> full clean pass.
//  5 LATENCY=0 with a combinational adder -> done after 257 cycles; pass=1.
//  6 After a failed run, start with a golden adder -> err_cnt, fail_a and
//    fail_b cleared; pass=1.

Source files
------------

// File: rtl/add_sweep_checker.sv
// Exhaustive sweep checker for a WIDTH-bit adder with LATENCY clocks of delay.
// Ports: clk, rst_n, start in; a, b operands out; c sum in;
//        busy, done, pass, err_cnt, fail_a, fail_b status out.
module add_sweep_checker #(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [WIDTH-1:0]   a,
    output logic [WIDTH-1:0]   b,
    input  logic [WIDTH:0]     c,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_cnt,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   fa_q, fa_d;
    logic [WIDTH-1:0]   fb_q, fb_d;
    logic [2*WIDTH:0]   err_q, err_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               sample;
    logic               last;
    logic [WIDTH:0]     expect_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            fa_q    <= '0;
            fb_q    <= '0;
            err_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign expect_sum = {1'b0, a_q} + {1'b0, b_q};
    assign last       = (a_q == '1) && (b_q == '1);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        fa_d    = fa_q;
        fb_d    = fb_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        sample  = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = '0;
                    b_d     = '0;
                    fa_d    = '0;
                    fb_d    = '0;
                    err_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (LATENCY == 0) begin
                    // combinational adder: c already reflects a,b
                    sample = 1'b1;
                end else begin
                    // remaining WAIT cycles before the CHECK cycle
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? S_CHECK : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                sample = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (sample) begin
            if (c != expect_sum) begin
                if (err_q != '1) begin
                    err_d = err_q + 1'b1;
                end
                if (err_q == '0) begin
                    fa_d = a_q;
                    fb_d = b_q;
                end
            end
            if (last) begin
                // operands stay on the final pair while DONE
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end else begin
                // b is the low half, so it steps fastest
                {a_d, b_d} = {a_q, b_q} + (2*WIDTH)'(1);
                state_d    = S_DRIVE;
            end
        end
    end

    assign a       = a_q;
    assign b       = b_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = done_q && (err_q == '0);
    assign err_cnt = err_q;
    assign fail_a  = fa_q;
    assign fail_b  = fb_q;

endmodule

// File: tb/tb_add_sweep_checker.sv
// Directed bench for add_sweep_checker: registered adder (LATENCY=1,
// optional c[4] stuck-at-0) and combinational adder (LATENCY=0).
module tb_add_sweep_checker;

    logic       clk;
    logic       rst_n;
    logic       start1, start0;
    logic       fault;
    logic [3:0] a1, b1, a0, b0;
    logic [4:0] c1, c0, sum1;
    logic       busy1, done1, pass1, busy0, done0, pass0;
    logic [8:0] err1, err0;
    logic [3:0] fa1, fb1, fa0, fb0;

    int errors = 0;
    int checks = 0;
    int n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sum1 = {1'b0, a1} + {1'b0, b1};
    always_ff @(posedge clk) c1 <= fault ? {1'b0, sum1[3:0]} : sum1;
    assign c0 = {1'b0, a0} + {1'b0, b0};

    add_sweep_checker #(.WIDTH(4), .LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a(a1), .b(b1), .c(c1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .fail_a(fa1), .fail_b(fb1)
    );

    add_sweep_checker #(.WIDTH(4), .LATENCY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .a(a0), .b(b0), .c(c0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0), .fail_a(fa0), .fail_b(fb0)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulses start on one DUT and counts posedges until done (start = edge 1).
    task automatic run(input bit sel, input bit repulse, output int cyc);
        @(negedge clk);
        if (sel) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        cyc = 1;
        #1;
        start1 = 1'b0;
        start0 = 1'b0;
        while (!(sel ? done0 : done1) && cyc < 2000) begin
            if (repulse && (cyc == 50 || cyc == 200)) start1 = 1'b1;
            @(posedge clk);
            cyc++;
            #1;
            start1 = 1'b0;
        end
        if (cyc >= 2000) check("timeout", cyc, 0);
    endtask

    initial begin
        rst_n  = 1'b0;
        start1 = 1'b0;
        start0 = 1'b0;
        fault  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a", a1, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_err", err1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_done", done1, 0);

        run(1'b0, 1'b0, n);
        check("s1_len", n, 513);
        check("s1_err", err1, 0);
        check("s1_pass", pass1, 1);
        check("s1_busy", busy1, 0);
        check("s1_a", a1, 15);
        check("s1_b", b1, 15);

        fault = 1'b1;
        run(1'b0, 1'b0, n);
        check("s2_len", n, 513);
        check("s2_err", err1, 120);
        check("s2_fa", fa1, 1);
        check("s2_fb", fb1, 15);
        check("s2_pass", pass1, 0);
        check("s2_done", done1, 1);

        fault = 1'b0;
        run(1'b0, 1'b0, n);
        check("s6_err", err1, 0);
        check("s6_fa", fa1, 0);
        check("s6_fb", fb1, 0);
        check("s6_pass", pass1, 1);

        run(1'b0, 1'b1, n);
        check("s3_len", n, 513);
        check("s3_pass", pass1, 1);
        check("s3_a", a1, 15);

        fault = 1'b1;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("s4_busy_pre", busy1, 1);
        repeat (99) @(negedge clk);
        check("s4_a_pre", a1, 3);
        rst_n = 1'b0;
        #1;
        check("s4_a", a1, 0);
        check("s4_b", b1, 0);
        check("s4_busy", busy1, 0);
        check("s4_err", err1, 0);
        check("s4_done", done1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("s4_idle", busy1, 0);
        fault = 1'b0;
        run(1'b0, 1'b0, n);
        check("s4_len", n, 513);
        check("s4_pass", pass1, 1);

        run(1'b1, 1'b0, n);
        check("s5_len", n, 257);
        check("s5_err", err0, 0);
        check("s5_pass", pass0, 1);
        check("s5_a", a0, 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
